// File: rtl/mul4_fitness_scorer.sv
// Scores one mul4 candidate per vector against a golden product from a sequential
// shift-add multiplier, accumulating matched-bit fitness over a run of NUM_VECTORS.
//
// state  | meaning
// S_IDLE | ready for a tuple (in_ready=1)
// S_MUL  | 2*WORD_W shift-add steps, then one cycle registering the compare results
// S_CMP  | last_valid pulse; choose between the next vector and run completion
// S_DONE | run complete; waits for clear
module mul4_fitness_scorer #(
  parameter int WORD_W      = 16,
  parameter int NUM_VECTORS = 64,
  parameter int SCORE_W     = 13,
  parameter int MATCH_W     = $clog2(4*WORD_W+1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [WORD_W-1:0]  i_a1,
  input  logic [WORD_W-1:0]  i_a0,
  input  logic [WORD_W-1:0]  i_b1,
  input  logic [WORD_W-1:0]  i_b0,
  input  logic [WORD_W-1:0]  i_y3,
  input  logic [WORD_W-1:0]  i_y2,
  input  logic [WORD_W-1:0]  i_y1,
  input  logic [WORD_W-1:0]  i_y0,
  output logic               o_last_valid,
  output logic [MATCH_W-1:0] o_last_match,
  output logic [SCORE_W-1:0] o_exact_cnt,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] o_vec_cnt,
  output logic               o_done
);

  localparam int OPD_W  = 2*WORD_W;
  localparam int PROD_W = 4*WORD_W;
  localparam int IDX_W  = $clog2(OPD_W+1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OPD_W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_CMP, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_in_ready;
  logic                w_done;
  logic                w_accept;
  logic [PROD_W-1:0]   r_acc;
  logic [PROD_W-1:0]   r_a_sh;
  logic [OPD_W-1:0]    r_b_sh;
  logic [PROD_W-1:0]   r_y;
  logic [IDX_W-1:0]    r_bit_idx;
  logic                r_last_valid;
  logic [MATCH_W-1:0]  r_last_match;
  logic [SCORE_W-1:0]  r_exact_cnt;
  logic [SCORE_W-1:0]  r_score;
  logic [SCORE_W-1:0]  r_vec_cnt;
  logic [PROD_W-1:0]   w_same;
  logic [MATCH_W-1:0]  w_match;
  logic                w_exact;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (i_in_valid) w_next = S_MUL;
      end
      S_MUL: begin
        if (r_bit_idx == LAST_IDX) w_next = S_CMP;
      end
      S_CMP: begin
        // vec_cnt already holds the incremented count here
        if (r_vec_cnt == SCORE_W'(NUM_VECTORS)) w_next = S_DONE;
        else                                    w_next = S_IDLE;
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
    if (i_clear) w_next = S_IDLE;
  end

  assign w_accept   = w_in_ready && i_in_valid && !i_clear;
  assign o_in_ready = w_in_ready && i_rst_n;
  assign o_done     = w_done;

  assign w_same  = ~(r_acc ^ r_y);
  assign w_exact = (r_acc == r_y);

  always_comb begin
    w_match = '0;
    for (int k = 0; k < PROD_W; k++) begin
      w_match = w_match + MATCH_W'(w_same[k]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc        <= '0;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_y          <= '0;
      r_bit_idx    <= '0;
      r_last_valid <= 1'b0;
      r_last_match <= '0;
      r_exact_cnt  <= '0;
      r_score      <= '0;
      r_vec_cnt    <= '0;
    end else begin
      r_last_valid <= 1'b0;
      if (i_clear) begin
        r_acc        <= '0;
        r_bit_idx    <= '0;
        r_last_match <= '0;
        r_exact_cnt  <= '0;
        r_score      <= '0;
        r_vec_cnt    <= '0;
      end else if (w_accept) begin
        r_acc     <= '0;
        r_a_sh    <= {{OPD_W{1'b0}}, i_a1, i_a0};
        r_b_sh    <= {i_b1, i_b0};
        r_y       <= {i_y3, i_y2, i_y1, i_y0};
        r_bit_idx <= '0;
      end else if (r_state == S_MUL) begin
        if (r_bit_idx != LAST_IDX) begin
          if (r_b_sh[0]) r_acc <= r_acc + r_a_sh;
          r_a_sh    <= r_a_sh << 1;
          r_b_sh    <= r_b_sh >> 1;
          r_bit_idx <= r_bit_idx + IDX_W'(1);
        end else begin
          // product is final; commit this vector's result on entry to S_CMP
          r_last_valid <= 1'b1;
          r_last_match <= w_match;
          r_score      <= r_score + SCORE_W'(w_match);
          r_vec_cnt    <= r_vec_cnt + SCORE_W'(1);
          r_exact_cnt  <= r_exact_cnt + SCORE_W'(w_exact);
        end
      end
    end
  end

  assign o_last_valid = r_last_valid;
  assign o_last_match = r_last_match;
  assign o_exact_cnt  = r_exact_cnt;
  assign o_score      = r_score;
  assign o_vec_cnt    = r_vec_cnt;

endmodule
